axi_rotary_capture_fifo: RTL and testbench

//  AXI4-Lite slave that time-tags encoder sync events from N_CH trigger inputs. Each event's

---
 rtl/axi_rotary_capture_fifo.sv | 247 ++++++++++++++++++++++++
 tb/tb_axi_rotary_capture_fifo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rotary_capture_fifo.sv
// AXI4-Lite slave that queues time-tagged encoder sync events in a DEPTH-entry FIFO.
// Optional ROT_SYNC_EDGE_EN: 2-FF synchroniser + rising-edge detect on each sync_trg.
module axi_rotary_capture_fifo #(
  parameter int N_CH       = 4,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESET,
  input  logic [N_CH-1:0]       sync_trg,
  input  logic [31:0]           rot_pos,
  input  logic [31:0]           time_stamp,
  input  logic [15:0]           clk_counter,
  output logic                  interrupt,
  output logic                  z_en,
  input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]            S_AXI_AWPROT,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [31:0]           S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]            S_AXI_ARPROT,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB, S_AXI_WDATA,
                       S_AXI_AWADDR, S_AXI_ARADDR};

  // ---------------- trigger conditioning ----------------
  logic [N_CH-1:0] trg_evt;
`ifdef ROT_SYNC_EDGE_EN
  logic [N_CH-1:0] trg_s1, trg_s2, trg_s3, trg_ev;
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      trg_s1 <= '0; trg_s2 <= '0; trg_s3 <= '0; trg_ev <= '0;
    end else begin
      trg_s1 <= sync_trg;
      trg_s2 <= trg_s1;
      trg_s3 <= trg_s2;
      trg_ev <= trg_s2 & ~trg_s3;
    end
  end
  assign trg_evt = trg_ev;
`else
  assign trg_evt = sync_trg;
`endif

  // ---------------- AXI handshakes ----------------
  logic       aw_wready, aw_en, bvalid, arready, rvalid;
  logic [2:0] araddr;
  logic [31:0] rdata, rd_mux;
  logic       wr_fire, rd_fire;
  logic [2:0] wa;

  assign wr_fire = aw_wready & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_fire = arready & S_AXI_ARVALID & ~rvalid;
  assign wa      = S_AXI_AWADDR[4:2];

  assign S_AXI_AWREADY = aw_wready;
  assign S_AXI_WREADY  = aw_wready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = 2'b00;

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      aw_wready <= 1'b0; aw_en <= 1'b1; bvalid <= 1'b0;
      arready <= 1'b0; araddr <= '0; rvalid <= 1'b0; rdata <= '0;
    end else begin
      if (~aw_wready & S_AXI_AWVALID & S_AXI_WVALID & aw_en) begin
        aw_wready <= 1'b1;
        aw_en     <= 1'b0;
      end else begin
        aw_wready <= 1'b0;
        if (bvalid & S_AXI_BREADY) aw_en <= 1'b1;
      end
      if (wr_fire & ~bvalid)           bvalid <= 1'b1;
      else if (bvalid & S_AXI_BREADY)  bvalid <= 1'b0;

      if (~arready & S_AXI_ARVALID & ~rvalid) begin
        arready <= 1'b1;
        araddr  <= S_AXI_ARADDR[4:2];
      end else begin
        arready <= 1'b0;
      end
      if (rd_fire) begin
        rvalid <= 1'b1;
        rdata  <= rd_mux;
      end else if (rvalid & S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

  // ---------------- control registers ----------------
  logic        irq_en, overflow;
  logic [8:0]  thr, thr_eff;
  logic [15:0] drop_cnt;
  logic        flush, ovf_clr, drop_clr;

  assign flush    = wr_fire & (wa == 3'd1) & S_AXI_WDATA[3];
  assign ovf_clr  = wr_fire & (wa == 3'd1) & S_AXI_WDATA[0];
  assign drop_clr = wr_fire & (wa == 3'd6);
  assign thr_eff  = (thr == 9'd0) ? 9'd1 : thr;

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      z_en <= 1'b1; irq_en <= 1'b0; thr <= 9'd1;
    end else if (wr_fire) begin
      if (wa == 3'd1) begin
        z_en   <= S_AXI_WDATA[1];
        irq_en <= S_AXI_WDATA[2];
      end
      if (wa == 3'd5) thr <= S_AXI_WDATA[8:0];
    end
  end

  // ---------------- capture + arbitration ----------------
  logic [N_CH-1:0] pend, gnt, capture, retrig;
  logic [31:0]     sh_rot [N_CH];
  logic [31:0]     sh_ts  [N_CH];
  logic [15:0]     sh_cc  [N_CH];
  logic [31:0]     g_rot, g_ts;
  logic [15:0]     g_cc;
  logic [3:0]      g_ch;
  logic            any_gnt, push, pop, full_drop, empty, full;
  logic [4:0]      n_drop;
  logic [8:0]      level;
  logic [PW-1:0]   wr_ptr, rd_ptr;

  assign capture   = trg_evt & ~pend & {N_CH{~flush}};
  assign retrig    = trg_evt &  pend & {N_CH{~flush}};
  assign any_gnt   = |pend;
  assign empty     = (level == 9'd0);
  assign full      = (level == 9'(DEPTH));
  assign pop       = rd_fire & (araddr == 3'd4) & ~empty & ~flush;
  // a full FIFO still accepts the push when a pop frees the slot on the same edge
  assign push      = any_gnt & (~full | pop) & ~flush;
  assign full_drop = any_gnt & full & ~pop & ~flush;

  always_comb begin
    gnt = '0; g_rot = '0; g_ts = '0; g_cc = '0; g_ch = '0;
    for (int i = N_CH-1; i >= 0; i--) begin
      if (pend[i]) begin
        gnt   = '0;
        gnt[i] = 1'b1;
        g_rot = sh_rot[i];
        g_ts  = sh_ts[i];
        g_cc  = sh_cc[i];
        g_ch  = 4'(i);
      end
    end
  end

  always_comb begin
    n_drop = 5'(full_drop);
    for (int i = 0; i < N_CH; i++) n_drop = n_drop + 5'(retrig[i]);
  end

  always_ff @(posedge S_AXI_ACLK) begin
    for (int i = 0; i < N_CH; i++) begin
      if (capture[i]) begin
        sh_rot[i] <= rot_pos;
        sh_ts[i]  <= time_stamp;
        sh_cc[i]  <= clk_counter;
      end
    end
  end

  // ---------------- FIFO ----------------
  logic [31:0] mem_rot [DEPTH];
  logic [31:0] mem_ts  [DEPTH];
  logic [15:0] mem_cc  [DEPTH];
  logic [3:0]  mem_ch  [DEPTH];

  always_ff @(posedge S_AXI_ACLK) begin
    if (push) begin
      mem_rot[wr_ptr] <= g_rot;
      mem_ts[wr_ptr]  <= g_ts;
      mem_cc[wr_ptr]  <= g_cc;
      mem_ch[wr_ptr]  <= g_ch;
    end
  end

  logic [16:0] drop_sum;
  assign drop_sum = {1'b0, drop_cnt} + {12'b0, n_drop};

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      pend <= '0; wr_ptr <= '0; rd_ptr <= '0; level <= '0;
      drop_cnt <= '0; overflow <= 1'b0; interrupt <= 1'b0;
    end else begin
      if (flush) begin
        pend <= '0; wr_ptr <= '0; rd_ptr <= '0; level <= '0;
      end else begin
        pend <= (pend & ~gnt) | capture;
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        level <= level + 9'(push) - 9'(pop);
      end
      if (drop_clr)         drop_cnt <= '0;
      else if (drop_sum[16]) drop_cnt <= 16'hFFFF;
      else                  drop_cnt <= drop_sum[15:0];
      if (n_drop != 5'd0)   overflow <= 1'b1;
      else if (ovf_clr)     overflow <= 1'b0;
      interrupt <= irq_en & (level >= thr_eff);
    end
  end

  // ---------------- read mux ----------------
  logic [31:0] rot_q;
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) rot_q <= '0;
    else              rot_q <= rot_pos;
  end

  always_comb begin
    rd_mux = '0;
    case (araddr)
      3'd0: rd_mux = rot_q;
      3'd1: rd_mux = {4'(N_CH-1), 3'b0, level, 10'b0,
                      full, empty, overflow, irq_en, z_en, interrupt};
      3'd2: rd_mux = empty ? 32'd0 : mem_ts[rd_ptr];
      3'd3: rd_mux = empty ? 32'd0 : {mem_ch[rd_ptr], 12'b0, mem_cc[rd_ptr]};
      3'd4: rd_mux = empty ? 32'd0 : mem_rot[rd_ptr];
      3'd5: rd_mux = {23'b0, thr};
      3'd6: rd_mux = {16'b0, drop_cnt};
      default: rd_mux = '0;
    endcase
  end
endmodule

// File: tb/tb_axi_rotary_capture_fifo.sv
// Scoreboard bench: reads push expected data, an R-channel monitor pops and compares.
module tb_axi_rotary_capture_fifo;
  localparam int N_CH = 4;
  localparam int DEPTH = 16;
`ifdef ROT_SYNC_EDGE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N_CH-1:0] sync_trg;
  logic [31:0] rot_pos, time_stamp;
  logic [15:0] clk_counter;
  logic interrupt, z_en;
  logic [4:0] awaddr, araddr;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [1:0] bresp, rresp;

  axi_rotary_capture_fifo #(.N_CH(N_CH), .DEPTH(DEPTH), .ADDR_WIDTH(5)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .sync_trg(sync_trg), .rot_pos(rot_pos), .time_stamp(time_stamp),
    .clk_counter(clk_counter), .interrupt(interrupt), .z_en(z_en),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(4'hF),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready)
  );

  typedef struct { logic [31:0] exp; string name; } exp_t;
  exp_t sbq[$];
  int errors = 0;
  int checks = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endfunction

  // R-channel monitor
  always @(negedge clk) begin
    if (!rst && rvalid && rready) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_read: got 0x%08h expected no response", rdata);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk(e.name, rdata, e.exp);
        checks++;
        if (rresp !== 2'b00) begin
          errors++;
          $display("FAIL %s_rresp: got %0d expected 0", e.name, rresp);
        end
      end
    end
  end

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 50);
    if (!awready) begin
      checks++; errors++;
      $display("FAIL write_timeout: got no AWREADY expected AWREADY at 0x%02h", a);
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!bvalid || bresp !== 2'b00) begin
      errors++;
      $display("FAIL write_bresp: got bvalid=%0b bresp=%0d expected 1/0", bvalid, bresp);
    end
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [4:0] a, input logic [31:0] exp, input string nm);
    int n;
    exp_t e;
    e.exp = exp; e.name = nm;
    sbq.push_back(e);
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 50);
    if (!arready) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no ARREADY expected ARREADY", nm);
      void'(sbq.pop_back());
    end
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse(input logic [N_CH-1:0] m, input logic [31:0] r,
                       input logic [31:0] ts, input logic [15:0] cc);
    @(negedge clk);
    sync_trg = m; rot_pos = r; time_stamp = ts; clk_counter = cc;
    @(negedge clk);
    sync_trg = '0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e6_ctrl, e6_drop;
    rst = 1'b1; sync_trg = '0; rot_pos = '0; time_stamp = '0; clk_counter = '0;
    awaddr = '0; araddr = '0; wdata = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: reset state
    chk("rst_irq", interrupt, 0);
    chk("rst_zen", z_en, 1);
    axi_read(5'h04, 32'h3000_0012, "rst_ctrl");
    axi_read(5'h18, 32'h0, "rst_drop");
    axi_read(5'h14, 32'h1, "rst_thr");
    axi_read(5'h1C, 32'h0, "reserved");
    rot_pos = 32'hCAFE_0001;
    @(negedge clk);
    axi_read(5'h00, 32'hCAFE_0001, "live_pos");

    // 2: single event, irq lag, pop
    axi_write(5'h04, 32'h6);
    axi_write(5'h14, 32'h1);
    pulse(4'b0100, 32'h0000_2222, 32'h100, 16'h0ABC);
    repeat (LAT) @(negedge clk);
    chk("irq_lag", interrupt, 0);
    @(negedge clk);
    chk("irq_set", interrupt, 1);
    axi_read(5'h08, 32'h100, "t2_ts");
    axi_read(5'h0C, 32'h2000_0ABC, "t2_ch");
    axi_read(5'h10, 32'h2222, "t2_pop");
    axi_read(5'h04, 32'h3000_0016, "t2_empty");
    chk("irq_clr", interrupt, 0);

    // 3: simultaneous ch0 and ch3
    pulse(4'b1001, 32'hAAAA, 32'h200, 16'h0033);
    rot_pos = 32'h0; time_stamp = 32'h999;
    repeat (3 + LAT) @(negedge clk);
    axi_read(5'h04, 32'h3002_0007, "t3_level");
    axi_read(5'h0C, 32'h0000_0033, "t3_ch0");
    axi_read(5'h08, 32'h200, "t3_ts0");
    axi_read(5'h10, 32'hAAAA, "t3_pop0");
    axi_read(5'h0C, 32'h3000_0033, "t3_ch3");
    axi_read(5'h08, 32'h200, "t3_ts3");
    axi_read(5'h10, 32'hAAAA, "t3_pop3");

    // 4: overfill by 3
    for (int i = 0; i < DEPTH + 3; i++) pulse(4'b0001, 32'h1000 + i, i, 16'h0);
    repeat (2 + LAT) @(negedge clk);
    axi_read(5'h04, 32'h3010_002F, "t4_full");
    axi_read(5'h18, 32'h3, "t4_drop");
    axi_write(5'h04, 32'h7);
    axi_read(5'h04, 32'h3010_0027, "t4_w1c");

    // 5: pop coincides with push while full
    fork
      begin
        repeat (LAT) @(negedge clk);
        axi_read(5'h10, 32'h1000, "t5_oldest");
      end
      begin
        @(negedge clk);
        sync_trg = 4'b0010; rot_pos = 32'hBEEF;
        @(negedge clk);
        sync_trg = '0;
      end
    join
    repeat (2 + LAT) @(negedge clk);
    axi_read(5'h04, 32'h3010_0027, "t5_level");
    axi_read(5'h18, 32'h3, "t5_nodrop");
    for (int i = 1; i < DEPTH; i++) axi_read(5'h10, 32'h1000 + i, "t5_drain");
    axi_read(5'h10, 32'hBEEF, "t5_new");
    axi_read(5'h10, 32'h0, "t5_empty_pop");
    axi_read(5'h04, 32'h3000_0016, "t5_empty");

    // threshold boundaries: 2 blocks one entry, 0 acts as 1
    axi_write(5'h14, 32'h2);
    pulse(4'b0001, 32'h55, 32'h0, 16'h0);
    repeat (2 + LAT) @(negedge clk);
    chk("thr2_no_irq", interrupt, 0);
    axi_write(5'h14, 32'h0);
    repeat (2) @(negedge clk);
    chk("thr0_as1", interrupt, 1);
    axi_read(5'h10, 32'h55, "thr_pop");

    // 6: held trigger
    axi_write(5'h18, 32'h0);
    axi_read(5'h18, 32'h0, "drop_clear");
    @(negedge clk);
    sync_trg = 4'b0010;
    repeat (10) @(negedge clk);
    sync_trg = '0;
    repeat (4 + LAT) @(negedge clk);
`ifdef ROT_SYNC_EDGE_EN
    e6_ctrl = 32'h3001_0007; e6_drop = 32'h0;
`else
    e6_ctrl = 32'h3005_000F; e6_drop = 32'h5;
`endif
    axi_read(5'h04, e6_ctrl, "t6_ctrl");
    axi_read(5'h18, e6_drop, "t6_drop");

    axi_write(5'h04, 32'h4);
    chk("zen_clear", z_en, 0);

    // reset mid-operation
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_irq", interrupt, 0);
    chk("rst2_zen", z_en, 1);
    rst = 1'b0;
    @(negedge clk);
    axi_read(5'h04, 32'h3000_0012, "rst2_ctrl");
    axi_read(5'h18, 32'h0, "rst2_drop");
    axi_read(5'h14, 32'h1, "rst2_thr");
    axi_read(5'h10, 32'h0, "rst2_pop");

    for (int n = 0; n < 20 && sbq.size() != 0; n++) @(negedge clk);
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL pending_reads: got %0d outstanding expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
